// File: rtl/uart_rx_framer.sv
// Oversampling UART receiver feeding an async FIFO write port in the wclk domain.
// Define UART_PARITY_EN to add a parity bit, the PARITY_ODD parameter and a sticky parity_err output.
module uart_rx_framer #(
    parameter int DATASIZE   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 27
`ifdef UART_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                rx,
    input  logic                wfull,
    input  logic                clr_err,
    output logic [DATASIZE-1:0] wdata,
    output logic                wclken,
    output logic                busy,
    output logic                frame_err,
    output logic                overrun
`ifdef UART_PARITY_EN
    , output logic              parity_err
`endif
);

    localparam int DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATASIZE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state, w_state_next;
    logic                r_sync1, r_sync2, r_rx_prev;
    logic [DIV_W-1:0]    r_div;
    logic [SAMP_W-1:0]   r_samp;
    logic [BIT_W-1:0]    r_bitidx;
    logic [DATASIZE-1:0] r_shift;
    logic [DATASIZE-1:0] r_wdata;
    logic                r_wclken, r_frame_err, r_overrun;

    logic w_rx_s, w_fall, w_tick, w_half, w_full, w_last_bit;
    logic w_start_edge, w_start_ok, w_data_sample, w_stop_sample, w_par_ok;
    logic w_write, w_drop, w_frame_bad;

    assign w_rx_s     = r_sync2;
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_tick     = (r_div == DIV_W'(BAUD_DIV - 1));
    assign w_half     = w_tick && (r_samp == SAMP_W'(OVERSAMPLE / 2 - 1));
    assign w_full     = w_tick && (r_samp == SAMP_W'(OVERSAMPLE - 1));
    assign w_last_bit = (r_bitidx == BIT_W'(DATASIZE - 1));

    assign w_start_edge  = (r_state == S_IDLE) && w_fall;
    assign w_start_ok    = (r_state == S_START) && w_half && !w_rx_s;
    assign w_data_sample = (r_state == S_DATA) && w_full;
    assign w_stop_sample = (r_state == S_STOP) && w_full;

    assign w_write     = w_stop_sample && w_rx_s && !wfull && w_par_ok;
    assign w_drop      = w_stop_sample && w_rx_s && wfull && w_par_ok;
    assign w_frame_bad = w_stop_sample && !w_rx_s;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_next = S_START;
            S_START:  if (w_half) w_state_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_full && w_last_bit) begin
`ifdef UART_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (w_full) w_state_next = S_STOP;
            S_STOP:   if (w_full) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Restarting divider and sample count on the start edge aligns sampling to bit centres.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_div    <= '0;
            r_samp   <= '0;
            r_bitidx <= '0;
            r_shift  <= '0;
        end else begin
            if (w_start_edge || w_tick) r_div <= '0;
            else                        r_div <= r_div + DIV_W'(1);

            if (w_start_edge || w_start_ok) r_samp <= '0;
            else if (w_tick)                r_samp <= (r_samp == SAMP_W'(OVERSAMPLE - 1)) ? '0 : r_samp + SAMP_W'(1);

            if (w_start_ok)         r_bitidx <= '0;
            else if (w_data_sample) r_bitidx <= r_bitidx + BIT_W'(1);

            if (w_data_sample) r_shift <= {w_rx_s, r_shift[DATASIZE-1:1]};
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wdata     <= '0;
            r_wclken    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_wclken <= w_write;
            if (w_write) r_wdata <= r_shift;

            if (w_frame_bad)  r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;

            if (w_drop)       r_overrun <= 1'b1;
            else if (clr_err) r_overrun <= 1'b0;
        end
    end

`ifdef UART_PARITY_EN
    logic r_par_bad, r_parity_err, w_par_sample;

    assign w_par_sample = (r_state == S_PARITY) && w_full;
    assign w_par_ok     = ~r_par_bad;
    assign parity_err   = r_parity_err;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_sample) r_par_bad <= (w_rx_s != ((^r_shift) ^ PARITY_ODD));

            if (w_par_sample && (w_rx_s != ((^r_shift) ^ PARITY_ODD))) r_parity_err <= 1'b1;
            else if (clr_err)                                          r_parity_err <= 1'b0;
        end
    end
`else
    assign w_par_ok = 1'b1;
`endif

    assign wdata     = r_wdata;
    assign wclken    = r_wclken;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: stimulus pushes expected bytes, a monitor pops them on wclken.
module tb_uart_rx_framer;

    localparam int DW   = 8;
    localparam int OS   = 16;
    localparam int BD   = 2;
    localparam int BITC = OS * BD;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          rx = 1'b1;
    logic          wfull = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] wdata;
    logic          wclken, busy, frame_err, overrun;
`ifdef UART_PARITY_EN
    logic          parity_err;
    logic          bad_par = 1'b0;
`endif

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic          prev_en = 1'b0;

    always #5 wclk = ~wclk;

    uart_rx_framer #(.DATASIZE(DW), .OVERSAMPLE(OS), .BAUD_DIV(BD)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .rx        (rx),
        .wfull     (wfull),
        .clr_err   (clr_err),
        .wdata     (wdata),
        .wclken    (wclken),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cycles(BITC);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        send_bit((^d) ^ bad_par);
`endif
        send_bit(stop_bit);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
    endtask

    always @(negedge wclk) begin
        if (wclken) begin
            check("wclken_single_cycle", {31'b0, prev_en}, 32'h0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got wdata 0x%0h, required no write", wdata);
            end else begin
                check("wdata", {24'b0, wdata}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_en = wclken;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cycles(4);
        check("busy_in_reset", {31'b0, busy}, 32'h0);
        wrst = 1'b0;
        cycles(5);
        check("rst_wdata", {24'b0, wdata}, 32'h0);
        check("rst_wclken", {31'b0, wclken}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_frame_err", {31'b0, frame_err}, 32'h0);
        check("rst_overrun", {31'b0, overrun}, 32'h0);

        // 0xA5 clean frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        cycles(BITC);
        check("a5_writes_pending", exp_q.size(), 32'h0);
        check("a5_busy", {31'b0, busy}, 32'h0);
        check("a5_frame_err", {31'b0, frame_err}, 32'h0);
        check("a5_overrun", {31'b0, overrun}, 32'h0);

        // Short low glitch
        rx = 1'b0;
        cycles(6);
        check("glitch_busy_high", {31'b0, busy}, 32'h1);
        rx = 1'b1;
        cycles(BITC);
        check("glitch_busy_low", {31'b0, busy}, 32'h0);
        check("glitch_frame_err", {31'b0, frame_err}, 32'h0);
        check("glitch_overrun", {31'b0, overrun}, 32'h0);

        // Framing error, clear, then good frame
        send_frame(8'h3C, 1'b0);
        rx = 1'b1;
        cycles(BITC);
        check("fe_set", {31'b0, frame_err}, 32'h1);
        check("fe_writes_pending", exp_q.size(), 32'h0);
        pulse_clr();
        check("fe_cleared", {31'b0, frame_err}, 32'h0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        cycles(BITC);
        check("x11_writes_pending", exp_q.size(), 32'h0);
        check("x11_wdata_held", {24'b0, wdata}, 32'h11);

        // Overrun with wfull held
        wfull = 1'b1;
        send_frame(8'h7E, 1'b1);
        cycles(BITC);
        check("ovr_set", {31'b0, overrun}, 32'h1);
        check("ovr_wdata_kept", {24'b0, wdata}, 32'h11);
        wfull = 1'b0;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        cycles(BITC);
        check("x81_writes_pending", exp_q.size(), 32'h0);
        check("x81_wdata", {24'b0, wdata}, 32'h81);
        check("ovr_sticky", {31'b0, overrun}, 32'h1);

        // Back-to-back frames
        pulse_clr();
        check("ovr_cleared", {31'b0, overrun}, 32'h0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        cycles(BITC);
        check("b2b_writes_pending", exp_q.size(), 32'h0);
        check("b2b_frame_err", {31'b0, frame_err}, 32'h0);
        check("b2b_overrun", {31'b0, overrun}, 32'h0);

        // Reset mid-byte after bit 3 of 0x5A
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        cycles(4);
        check("midbyte_busy", {31'b0, busy}, 32'h1);
        wrst = 1'b1;
        cycles(3);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_wdata", {24'b0, wdata}, 32'h0);
        wrst = 1'b0;
        cycles(2 * BITC);
        check("abort_idle", {31'b0, busy}, 32'h0);
        check("abort_writes_pending", exp_q.size(), 32'h0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        cycles(BITC);
        check("x5a_writes_pending", exp_q.size(), 32'h0);
        check("x5a_wdata", {24'b0, wdata}, 32'h5A);

`ifdef UART_PARITY_EN
        // Wrong parity on 0x5A
        bad_par = 1'b1;
        send_frame(8'h5A, 1'b1);
        bad_par = 1'b0;
        cycles(BITC);
        check("par_err_set", {31'b0, parity_err}, 32'h1);
        check("par_writes_pending", exp_q.size(), 32'h0);
        check("par_frame_err", {31'b0, frame_err}, 32'h0);
        pulse_clr();
        check("par_err_cleared", {31'b0, parity_err}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial-to-parallel UART receiver, placed directly upstream of the async FIFO write port in the wclk domain.
- Oversamples the rx line, recovers 8N1 frames, and presents each valid byte as wdata with a one-cycle wclken write strobe.
- Respects the FIFO wfull flag and reports framing and overrun errors through sticky flags.

Parameters:
- DATASIZE, 8, data bits per frame; also the width of wdata.
- OVERSAMPLE, 16, oversample ticks per bit. Must be even and at least 4.
- BAUD_DIV, 27, wclk cycles per oversample tick (50 MHz / 115200 / 16 ≈ 27). Must be at least 1.

Ports:
- wclk, input, 1, receive-domain clock.
- wrst, input, 1, reset. Asynchronous, active-high.
- rx, input, 1, asynchronous serial line; idles high.
- wfull, input, 1, FIFO full flag, in the wclk domain.
- clr_err, input, 1, synchronous clear of the sticky error flags.
- wdata, output, DATASIZE, received byte.
- wclken, output, 1, one-cycle FIFO write strobe.
- busy, output, 1, high while a frame is in progress (any state other than IDLE).
- frame_err, output, 1, sticky flag: stop bit sampled low.
- overrun, output, 1, sticky flag: valid byte dropped because wfull was high.

Behaviour:
- Reset values: wdata=0, wclken=0, busy=0, frame_err=0, overrun=0. The synchronizer flops reset to 1; FSM resets to IDLE; all counters reset to 0.
- rx passes through a 2-flop synchronizer; rx_s is the second stage. An edge-detect flop holds the previous rx_s.
- Tick divider: counts 0..BAUD_DIV-1 and emits a one-cycle tick at BAUD_DIV-1. It is forced to 0 when a start edge is detected.
- Sample counter: counts ticks 0..OVERSAMPLE-1 within a bit.
- IDLE:
  - On a falling edge of rx_s (previous=1, current=0), go to START and clear both counters.
  - A level-low rx_s with no edge is ignored, so a held break does not retrigger.
- START:
  - At the tick with sample count = OVERSAMPLE/2-1 (mid start bit): if rx_s=0, go to DATA with sample count 0 and bit index 0.
  - Otherwise it was a glitch: return to IDLE with no output.
- DATA:
  - At each tick with sample count = OVERSAMPLE-1 (mid-bit), shift rx_s into the MSB of the shift register (data arrives LSB first) and increment the bit index.
  - After DATASIZE bits, go to STOP.
- STOP, at the mid-bit tick:
  - rx_s=1 and wfull=0: wdata <= shift register; wclken=1 for exactly the next wclk cycle.
  - rx_s=1 and wfull=1: no write; overrun <= 1; wdata is unchanged.
  - rx_s=0: no write; frame_err <= 1.
  - In all three cases, return to IDLE.
- wclken is never high for two consecutive cycles. wdata is stable while wclken=1 and holds its value until the next valid frame.
- Latency: wclken rises 1 wclk after the mid-stop sampling tick. Total ≈ (DATASIZE+1.5)·OVERSAMPLE·BAUD_DIV + 3 wclk from the start edge.
- clr_err=1 clears both sticky flags on the next clock. If a set event occurs in the same cycle as clr_err, the set wins.
- wrst asserted mid-frame aborts immediately. After release the block sits in IDLE and needs a fresh falling edge; the partial frame is discarded.
- Back-to-back frames: a start edge arriving during the stop-bit's second half is detected once the FSM is in IDLE, because the edge detector compares against the stop-bit high level.

Optional Feature:
- Macro: UART_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP, sampled at mid-bit.
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds output port parity_err: 1 bit, sticky, cleared by clr_err, reset 0.
  - On a parity mismatch, set parity_err and suppress the write (wclken stays 0). The stop-bit check still runs.
- When undefined: no PARITY state and no parity_err port; the frame is 8N1 exactly.

Test Plan (bench parameters: BAUD_DIV=2, OVERSAMPLE=16, i.e. 32 wclk per bit):
- Send 0xA5 as 8N1 with wfull=0 → a single wclken pulse with wdata=0xA5; frame_err=0, overrun=0; busy falls to 0 after the frame.
- Drive rx low for 6 wclk, then high → returns to IDLE from START; no wclken; flags remain 0.
- Send 0x3C with the stop bit driven low → frame_err=1, no wclken. Then pulse clr_err → frame_err=0. Then send 0x11 → wclken with wdata=0x11.
- Hold wfull=1 and send 0x7E → overrun=1, no wclken, wdata keeps its prior value. Release wfull and send 0x81 → wdata=0x81 and overrun stays 1.
- Send back-to-back 0x00 then 0xFF with no idle gap → two wclken pulses with wdata 0x00 then 0xFF, and no errors.
- Assert wrst mid-byte (after bit 3), release, then send 0x5A → exactly one write, of 0x5A. With UART_PARITY_EN and a wrong parity bit on 0x5A → parity_err=1 and no write.
